// File: rtl/fft_frame_buffer_if.sv
// Bus between the ADC-side frame buffer and the FFT: sample stream in, presented frame and status out.
interface fft_frame_buffer_if #(
  parameter int WIDTH    = 18,
  parameter int N        = 256,
  parameter int SAMPLE_W = 12
);
  logic [SAMPLE_W-1:0]        sample_in;
  logic                       sample_valid;
  logic                       fft_done;
  logic                       start;
  logic [0:N-1][WIDTH-1:0]    time_samples;
  logic                       fft_busy;
  logic                       overrun;
  logic [15:0]                drop_count;

  modport master (
    output sample_in, sample_valid, fft_done,
    input  start, time_samples, fft_busy, overrun, drop_count
  );

  modport slave (
    input  sample_in, sample_valid, fft_done,
    output start, time_samples, fft_busy, overrun, drop_count
  );
endinterface

// File: rtl/fft_frame_buffer.sv
// Ping-pong frame buffer: fills one N-point bank from the ADC while the FFT reads the other.
// Optional macro FFT_FRAME_BUFFER_SAMPLE_OFFSET_EN stores samples as signed (sample - midscale).
module fft_frame_buffer #(
  parameter int WIDTH    = 18,
  parameter int N        = 256,
  parameter int SAMPLE_W = 12
) (
  input logic                 clk,
  input logic                 rst,
  fft_frame_buffer_if.slave   bus
);
  localparam int IW = $clog2(N);
  localparam logic [0:0] S_FILL = 1'b0;
  localparam logic [0:0] S_FULL = 1'b1;

  logic [1:0][0:N-1][WIDTH-1:0] r_bank;
  logic                         r_wr_bank;
  logic [IW-1:0]                r_wr_idx;
  logic [0:0]                   r_state;
  logic                         r_start;
  logic                         r_busy;
  logic                         r_overrun;
  logic [15:0]                  r_drop;

  logic [WIDTH-1:0]             w_fmt;
  logic                         w_launch;

`ifdef FFT_FRAME_BUFFER_SAMPLE_OFFSET_EN
  // Inverting the MSB of an offset-binary sample yields its two's complement value.
  logic [SAMPLE_W-1:0] w_off;
  assign w_off = {~bus.sample_in[SAMPLE_W-1], bus.sample_in[SAMPLE_W-2:0]};
  assign w_fmt = WIDTH'($signed(w_off));
`else
  assign w_fmt = WIDTH'(bus.sample_in);
`endif

  assign w_launch = (r_state == S_FULL) && (!r_busy || bus.fft_done);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bank    <= '0;
      r_wr_bank <= 1'b0;
      r_wr_idx  <= '0;
      r_state   <= S_FILL;
      r_start   <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
      r_drop    <= '0;
    end else begin
      r_start <= 1'b0;
      if (bus.fft_done) r_busy <= 1'b0;
      case (r_state)
        S_FILL: begin
          if (bus.sample_valid) begin
            r_bank[r_wr_bank][r_wr_idx] <= w_fmt;
            r_wr_idx <= r_wr_idx + IW'(1);
            if (r_wr_idx == IW'(N - 1)) r_state <= S_FULL;
          end
        end
        default: begin
          if (w_launch) begin
            // A sample arriving on the swap edge opens the new write bank instead of being lost.
            r_wr_bank <= ~r_wr_bank;
            r_start   <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= S_FILL;
            if (bus.sample_valid) begin
              r_bank[~r_wr_bank][0] <= w_fmt;
              r_wr_idx <= IW'(1);
            end
          end else if (bus.sample_valid) begin
            r_overrun <= 1'b1;
            if (r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
          end
        end
      endcase
    end
  end

  assign bus.start        = r_start;
  assign bus.fft_busy     = r_busy;
  assign bus.overrun      = r_overrun;
  assign bus.drop_count   = r_drop;
  assign bus.time_samples = r_bank[~r_wr_bank];
endmodule

// File: doc/fft_frame_buffer.md
FFT_FRAME_BUFFER -- requirements
Module: fft_frame_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 18, setting the bit width of each word in the presented frame.
REQ-002 SHALL have parameter N, default 256, setting the number of points per frame; N must be a power of two.
REQ-003 SHALL have parameter SAMPLE_W, default 12, setting the bit width of the incoming audio samples.
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port sample_in  input  SAMPLE_W  unsigned ADC sample.
REQ-007 SHALL have port sample_valid  input  1  sample_in is valid this cycle.
REQ-008 SHALL have port fft_done  input  1  FFT finished the presented frame.
REQ-009 SHALL have port start  output  1  one-cycle pulse telling the FFT to begin.
REQ-010 SHALL have port time_samples  output  WIDTH x [0:N-1]  presented frame; index 0 holds the oldest sample.
REQ-011 SHALL have port fft_busy  output  1  high from start until fft_done is accepted.
REQ-012 SHALL have port overrun  output  1  sticky flag, set when a sample was dropped.
REQ-013 SHALL have port drop_count  output  16  number of dropped samples, saturating at 16'hFFFF.

Function
REQ-014 SHALL hold two N-entry banks (ping-pong): a write bank and a read bank; time_samples always shows the read bank.
REQ-015 SHALL register outputs only; there are no combinational paths from inputs to outputs.
REQ-016 SHALL, in FILL with sample_valid=1, store the formatted sample at wr_idx of the write bank and increment wr_idx.
REQ-017 SHALL set full and enter state FULL at the edge that accepts the sample at wr_idx=N-1; wr_idx then wraps to 0.
REQ-018 SHALL define the launch condition as: in FULL, and either fft_busy=0 or fft_done=1 in that same cycle.
REQ-019 SHALL, at the edge where the launch condition holds, do all of: swap banks; assert start=1 for exactly one cycle; set fft_busy=1; clear full; return to FILL.
REQ-020 SHALL therefore assert start in the cycle immediately after the last sample's accepting edge when the FFT is idle (latency 1 cycle).
REQ-021 SHALL, if sample_valid=1 on a launch edge, write that sample to index 0 of the new write bank, so wr_idx becomes 1; the sample is not dropped.
REQ-022 SHALL, in FULL without the launch condition, drop any sample with sample_valid=1: set overrun and increment drop_count, saturating.
REQ-023 SHALL keep the read bank unchanged from one start until the next start.
REQ-024 SHALL clear fft_busy on fft_done; fft_done while fft_busy=0 and not in FULL is ignored.
REQ-025 SHALL never assert start while fft_busy=1 unless fft_done=1 in that same cycle.
REQ-026 SHALL, without SAMPLE_OFFSET_EN, zero-extend sample_in to WIDTH bits.

Reset
REQ-027 SHALL, while rst=0, immediately force: start=0, fft_busy=0, overrun=0, drop_count=0, wr_idx=0, full=0, state FILL, write bank=0, read bank=1.
REQ-028 SHALL clear every entry of both banks to 0 on reset, so time_samples reads all zero.
REQ-029 SHALL, on reset during a fill or while FFT busy, discard the partial frame; the first post-reset sample goes to index 0.

Configuration
REQ-030 SHALL, when macro FFT_FRAME_BUFFER_SAMPLE_OFFSET_EN is defined, store (sample_in - 2**(SAMPLE_W-1)) sign-extended to WIDTH bits (two's complement); otherwise store per REQ-026.

Verification
REQ-031 SHALL check: reset, then 256 valid samples 1061, 235, ..., 1879 back-to-back -> start high one cycle after the 256th; time_samples[0]=1061, time_samples[255]=1879; fft_busy=1.
REQ-032 SHALL check: a second 256-sample frame while fft_done is never pulsed -> start stays 0; the next 10 valid samples are dropped, giving overrun=1 and drop_count=10; time_samples is unchanged.
REQ-033 SHALL check: in FULL, pulse fft_done in the same cycle as sample_valid with value 4044 -> start next cycle, new write bank index 0 = 4044, drop_count unchanged.
REQ-034 SHALL check: drive rst=0 mid-fill (after 100 samples) and while fft_busy=1 -> all outputs are zero immediately; a full 256-sample frame is needed before the next start.
REQ-035 SHALL check: with FFT_FRAME_BUFFER_SAMPLE_OFFSET_EN defined, sample 1061 -> time_samples[0]=18'h3FC25 (-987); sample 2048 -> 0; sample 4095 -> 2047.
REQ-036 SHALL check: 70000 samples dropped while held full -> drop_count saturates at 16'hFFFF.
